wb_dram_responder: RTL and testbench

- Wishbone classic responder that stands in for the DRAM wrapper on the same 256-bit bus.
- Backed by an on-chip single-port RAM with programmable access latency and a memory-clearing init phase that drives `initialized`.
- Lets the board test harness and any future bus initiators run without DDR3 hardware, with deterministic timing.
- Slot-in replacement for the wrapper's user-side ports.

---
 rtl/wb_resp_pkg.sv | 22 ++
 rtl/wb_resp_mem.sv | 27 ++
 rtl/wb_dram_responder.sv | 164 ++++++++++++++++
 tb/tb_wb_dram_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone DRAM stand-in responder.
package wb_resp_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StIdle    = 2'd1,
    StBusy    = 2'd2,
    StRelease = 2'd3
  } resp_state_t;

  // Width of the completed-transfer counters.
  localparam int unsigned CNT_W = 16;

  // Word index of a byte address; upper bits alias modulo depth.
  function automatic logic [31:0] idx_of(input logic [31:0] addr,
                                         input int unsigned idx_lsb,
                                         input int unsigned depth);
    return (addr >> idx_lsb) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// Single-port synchronous RAM with registered read; contents are not reset.
module wb_resp_mem #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write or registered read of one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata <= mem_q[idx];
      end
    end
  end

endmodule

// File: rtl/wb_dram_responder.sv
// Wishbone classic responder backed by on-chip RAM, with fixed access latency
// and a RAM-clearing init phase.
module wb_dram_responder
  import wb_resp_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 256,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_LSB   = 7,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 sys_clk_100mhz,
  input  logic                 rst_n,
  output logic                 initialized,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 ack_o,
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_t          state_q, state_d;
  logic [IdxW-1:0]      clr_idx_q, clr_idx_d;
  logic [IdxW-1:0]      cap_idx_q, cap_idx_d;
  logic                 cap_we_q, cap_we_d;
  logic [WORD_SIZE-1:0] cap_data_q, cap_data_d;
  logic [LatW-1:0]      lat_q, lat_d;
  logic                 ack_q, ack_d;
  logic                 init_q, init_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     wr_q, wr_d, rd_q, rd_d;

  logic                 mem_en, mem_we;
  logic [IdxW-1:0]      mem_idx;
  logic [WORD_SIZE-1:0] mem_wdata, mem_rdata;
  logic [31:0]          req_idx_full;
  logic [IdxW-1:0]      req_idx;

  assign req_idx_full = idx_of(addr_i, IDX_LSB, DEPTH);
  assign req_idx      = req_idx_full[IdxW-1:0];

  // Next-state, capture, completion and RAM port muxing.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    cap_idx_d  = cap_idx_q;
    cap_we_d   = cap_we_q;
    cap_data_d = cap_data_q;
    lat_d      = lat_q;
    ack_d      = 1'b0;
    init_d     = init_q;
    rdata_d    = rdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = cap_idx_q;
    mem_wdata  = cap_data_q;

    unique case (state_q)
      StInit: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_wdata = '0;
        if (clr_idx_q == IdxW'(DEPTH - 1)) begin
          state_d = StIdle;
          init_d  = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + IdxW'(1);
        end
      end
      StIdle: begin
        mem_idx = req_idx;
        if (cyc_i && stb_i) begin
          // Start the read now so registered RAM data is ready for LATENCY=1.
          mem_en     = 1'b1;
          cap_idx_d  = req_idx;
          cap_we_d   = we_i;
          cap_data_d = data_i;
          lat_d      = LatW'(LATENCY - 1);
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (!cyc_i) begin
          state_d = StIdle;
        end else if (lat_q != '0) begin
          lat_d  = lat_q - LatW'(1);
          mem_en = !cap_we_q;
        end else begin
          if (cap_we_q) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            wr_d   = wr_q + CNT_W'(1);
          end else begin
            rdata_d = mem_rdata;
            rd_d    = rd_q + CNT_W'(1);
          end
          ack_d   = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk_100mhz) begin
    if (!rst_n) begin
      state_q    <= StInit;
      clr_idx_q  <= '0;
      cap_idx_q  <= '0;
      cap_we_q   <= 1'b0;
      cap_data_q <= '0;
      lat_q      <= '0;
      ack_q      <= 1'b0;
      init_q     <= 1'b0;
      rdata_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      cap_idx_q  <= cap_idx_d;
      cap_we_q   <= cap_we_d;
      cap_data_q <= cap_data_d;
      lat_q      <= lat_d;
      ack_q      <= ack_d;
      init_q     <= init_d;
      rdata_q    <= rdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // Gate with reset so a write completing on a reset edge is dropped.
  wb_resp_mem #(
    .WIDTH (WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (sys_clk_100mhz),
    .en    (mem_en && rst_n),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign initialized = init_q;
  assign ack_o       = ack_q;
  assign data_o      = rdata_q;
  assign wr_count    = wr_q;
  assign rd_count    = rd_q;

endmodule

// File: tb/tb_wb_dram_responder.sv
// Self-checking bench for wb_dram_responder: time-based transfer model plus
// literal checks of the headline scenarios.
module tb_wb_dram_responder;

  localparam int unsigned W     = 256;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LSB   = 7;
  localparam int unsigned LAT   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0]   addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          initialized, ack;
  logic [W-1:0]  rdata;
  logic [15:0]   wr_cnt, rd_cnt;

  always #5 clk = ~clk;

  wb_dram_responder #(
    .WORD_SIZE (W),
    .DEPTH     (DEPTH),
    .IDX_LSB   (LSB),
    .LATENCY   (LAT)
  ) dut (
    .sys_clk_100mhz (clk),
    .rst_n          (rst_n),
    .initialized    (initialized),
    .cyc_i          (cyc),
    .stb_i          (stb),
    .we_i           (we),
    .addr_i         (addr),
    .data_i         (wdata),
    .data_o         (rdata),
    .ack_o          (ack),
    .wr_count       (wr_cnt),
    .rd_count       (rd_cnt)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model (edge-numbered timeline) -------------
  logic [W-1:0] m_mem [DEPTH];
  bit           m_valid = 0, m_init = 0, m_ack = 0, m_act = 0, m_we = 0;
  int           edge_n = 0, init_at = 0, free_at = 0, cap_edge = 0, m_idx = 0;
  logic [W-1:0] m_cap = '0, m_data = '0;
  logic [15:0]  m_wr = '0, m_rd = '0;

  task automatic model_step();
    edge_n++;
    m_ack = 0;
    if (!rst_n) begin
      m_valid = 1; m_init = 0; m_act = 0; m_data = '0; m_wr = '0; m_rd = '0;
      init_at = edge_n + DEPTH;
      free_at = init_at + 1;
      return;
    end
    if (!m_valid) return;
    if (edge_n == init_at) begin
      m_init = 1;
      foreach (m_mem[i]) m_mem[i] = '0;
    end
    if (m_act) begin
      if (!cyc) begin
        m_act = 0;
        free_at = edge_n + 1;
      end else if (edge_n == cap_edge + int'(LAT)) begin
        if (m_we) begin
          m_mem[m_idx] = m_cap;
          m_wr++;
        end else begin
          m_data = m_mem[m_idx];
          m_rd++;
        end
        m_ack = 1;
        m_act = 0;
        free_at = edge_n + 2;
      end
    end else if (edge_n >= free_at && cyc && stb) begin
      m_act = 1;
      cap_edge = edge_n;
      m_we = we;
      m_idx = int'((addr >> LSB) % DEPTH);
      m_cap = wdata;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("ack_o", W'(ack), W'(m_ack));
      check("initialized", W'(initialized), W'(m_init));
      check("data_o", rdata, m_data);
      check("wr_count", W'(wr_cnt), W'(m_wr));
      check("rd_count", W'(rd_cnt), W'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Full transfer; wiggles captured-only inputs while busy.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [W-1:0] d,
                      input bit wiggle, output logic [W-1:0] r, output int lat);
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ack && wiggle) begin
        we = $urandom_range(0, 1); addr = $urandom; wdata = rand_word();
      end
    end while (!ack && n < 100);
    if (n >= 100) check("xfer_timeout", W'(n), W'(LAT + 1));
    r = rdata;
    lat = n;
    cyc = 0; stb = 0;
  endtask

  // Transfer dropped by deasserting cyc k cycles after capture.
  task automatic abort_xfer(input logic [31:0] a, input logic [W-1:0] d, input int k,
                            output int acks);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = a; wdata = d;
    acks = 0;
    repeat (k) begin
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (ack) acks++;
    end
  endtask

  logic [W-1:0] pat2, pat5a, ones, r;
  int           lat, n, acks, first_ack, second_ack, early_acks;

  initial begin
    pat2  = {2{128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899}};
    pat5a = {32{8'h5A}};
    ones  = '1;

    // 1: reset and init clear.
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    n = 0;
    while (!initialized && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_rise_cycle", W'(n), W'(16));
    check("init_wr_count", W'(wr_cnt), W'(0));
    check("init_data_o", rdata, '0);

    // 2: write then read back, latency measured from capture.
    xfer(1, 32'h0000_0000, pat2, 1, r, lat);
    check("t2_wr_latency", W'(lat), W'(LAT + 1));
    xfer(0, 32'h0000_0000, '0, 1, r, lat);
    check("t2_rd_latency", W'(lat), W'(LAT + 1));
    check("t2_rd_data", r, pat2);
    check("t2_wr_count", W'(wr_cnt), W'(1));
    check("t2_rd_count", W'(rd_cnt), W'(1));

    // 3: unwritten word reads as cleared.
    xfer(0, 32'h0000_0080, '0, 0, r, lat);
    check("t3_rd_data", r, '0);
    check("t3_rd_count", W'(rd_cnt), W'(2));

    // 4: address aliasing modulo DEPTH.
    xfer(1, 32'h0000_0800, pat5a, 0, r, lat);
    xfer(0, 32'h0000_0000, '0, 0, r, lat);
    check("t4_alias_data", r, pat5a);
    check("t4_wr_count", W'(wr_cnt), W'(2));

    // 5: aborted write leaves RAM and counters alone.
    abort_xfer(32'h0000_0180, ones, 2, acks);
    check("t5_abort_acks", W'(acks), W'(0));
    check("t5_wr_count", W'(wr_cnt), W'(2));
    xfer(0, 32'h0000_0180, '0, 0, r, lat);
    check("t5_rd_data", r, '0);
    check("t5_rd_count", W'(rd_cnt), W'(4));

    // Randomized traffic checked by the model.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        abort_xfer($urandom, rand_word(), $urandom_range(1, LAT - 1), acks);
      end else begin
        xfer($urandom_range(0, 1), $urandom, rand_word(), 1, r, lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 6: request held across init, then back-to-back with stb held.
    @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    first_ack = 0; second_ack = 0; early_acks = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 5) begin
        cyc = 1; stb = 1; we = 0; addr = 32'h0000_0080;
      end
      if (ack) begin
        if (first_ack == 0) first_ack = j;
        else if (second_ack == 0) second_ack = j;
      end
      if (ack && j < 21) early_acks++;
    end
    cyc = 0; stb = 0;
    check("t6_no_ack_in_init", W'(early_acks), W'(0));
    check("t6_first_ack", W'(first_ack), W'(21));
    check("t6_second_ack", W'(second_ack), W'(27));
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
